// File: rtl/ets_phase_sweep.sv
// Equivalent-time phase sweep: steps the MMCM fine phase and emits a per-step ones-count histogram.
// Optional ETS_SWEEP_RETURN_EN: shift back to the starting phase after the last beat.
module ets_phase_sweep #(
    parameter int NUM_CH      = 1,
    parameter int STEP_W      = 10,
    parameter int SAMP_W      = 8,
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                           free_run_clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           abort,
    input  logic [STEP_W-1:0]              cfg_steps,
    input  logic [SAMP_W-1:0]              cfg_samples,
    input  logic                           cfg_dir,
    input  logic [NUM_CH-1:0]              cmp_data,
    output logic                           ps_en,
    output logic                           ps_incdec,
    input  logic                           ps_done,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [STEP_W-1:0]              res_step,
    output logic [NUM_CH*(SAMP_W+1)-1:0]   res_count,
    output logic                           busy,
    output logic                           done,
    output logic                           err_timeout
);

    localparam int CNT_W    = SAMP_W + 1;
    localparam int WAIT_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

`ifdef ETS_SWEEP_RETURN_EN
    localparam bit RETURN_EN = 1'b1;
`else
    localparam bit RETURN_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, SAMPLE, EMIT, SHIFT, WAIT_DONE, SETTLE} state_t;

    state_t                          state;
    logic [STEP_W-1:0]               steps_q;
    logic [STEP_W-1:0]               ret_left;
    logic [SAMP_W-1:0]               last_samp;
    logic [SAMP_W-1:0]               samp_cnt;
    logic                            dir_q;
    logic                            abort_pend;
    logic                            returning;
    logic [WAIT_W-1:0]               wait_cnt;
    logic [NUM_CH-1:0][CNT_W-1:0]    counts;

    assign res_count = counts;

    always_ff @(posedge free_run_clk) begin
        if (reset) begin
            state       <= IDLE;
            steps_q     <= '0;
            ret_left    <= '0;
            last_samp   <= '0;
            samp_cnt    <= '0;
            dir_q       <= 1'b0;
            abort_pend  <= 1'b0;
            returning   <= 1'b0;
            wait_cnt    <= '0;
            counts      <= '0;
            ps_en       <= 1'b0;
            ps_incdec   <= 1'b0;
            res_valid   <= 1'b0;
            res_step    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            ps_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort && cfg_steps != '0) begin
                        steps_q     <= cfg_steps;
                        // cfg_samples==0 wraps to all-ones, i.e. 2**SAMP_W samples
                        last_samp   <= cfg_samples - SAMP_W'(1);
                        dir_q       <= cfg_dir;
                        err_timeout <= 1'b0;
                        abort_pend  <= 1'b0;
                        returning   <= 1'b0;
                        res_step    <= '0;
                        samp_cnt    <= '0;
                        counts      <= '0;
                        busy        <= 1'b1;
                        state       <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        for (int i = 0; i < NUM_CH; i++)
                            counts[i] <= counts[i] + CNT_W'(cmp_data[i]);
                        samp_cnt <= samp_cnt + SAMP_W'(1);
                        if (samp_cnt == last_samp) begin
                            res_valid <= 1'b1;
                            state     <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (abort) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (res_ready) begin
                        res_valid <= 1'b0;
                        if (res_step == steps_q - STEP_W'(1)) begin
                            if (RETURN_EN && steps_q != STEP_W'(1)) begin
                                returning <= 1'b1;
                                ret_left  <= steps_q - STEP_W'(1);
                                ps_en     <= 1'b1;
                                ps_incdec <= ~dir_q;
                                wait_cnt  <= '0;
                                state     <= SHIFT;
                            end else begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end else begin
                            ps_en     <= 1'b1;
                            ps_incdec <= dir_q;
                            wait_cnt  <= '0;
                            state     <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    // ps_en is already out; the MMCM must finish before we can leave
                    if (abort) abort_pend <= 1'b1;
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                    state    <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                    if (abort) abort_pend <= 1'b1;
                    if (ps_done) begin
                        if (abort_pend || abort) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else if (returning) begin
                            if (ret_left == STEP_W'(1)) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                ret_left <= ret_left - STEP_W'(1);
                                ps_en    <= 1'b1;
                                wait_cnt <= '0;
                                state    <= SHIFT;
                            end
                        end else if (SETTLE_CYC == 0) begin
                            res_step <= res_step + STEP_W'(1);
                            samp_cnt <= '0;
                            counts   <= '0;
                            state    <= SAMPLE;
                        end else begin
                            wait_cnt <= '0;
                            state    <= SETTLE;
                        end
                    end else if (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1)) begin
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (wait_cnt == WAIT_W'(SETTLE_CYC - 1)) begin
                        res_step <= res_step + STEP_W'(1);
                        samp_cnt <= '0;
                        counts   <= '0;
                        state    <= SAMPLE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ets_phase_sweep.sv
// Directed bench for ets_phase_sweep: table of full sweeps plus hand-timed stall/timeout/abort sequences.
module tb_ets_phase_sweep;

    localparam int NUM_CH = 2;
    localparam int STEP_W = 10;
    localparam int SAMP_W = 4;
    localparam int CW     = SAMP_W + 1;
    localparam int TMO    = 64;
`ifdef ETS_SWEEP_RETURN_EN
    localparam int RET = 1;
`else
    localparam int RET = 0;
`endif

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    start = 1'b0;
    logic                    abort = 1'b0;
    logic [STEP_W-1:0]       cfg_steps = '0;
    logic [SAMP_W-1:0]       cfg_samples = '0;
    logic                    cfg_dir = 1'b0;
    logic [NUM_CH-1:0]       cmp_data = '0;
    logic                    ps_en, ps_incdec;
    logic                    ps_done = 1'b0;
    logic                    res_valid;
    logic                    res_ready = 1'b1;
    logic [STEP_W-1:0]       res_step;
    logic [NUM_CH*CW-1:0]    res_count;
    logic                    busy, done, err_timeout;

    ets_phase_sweep #(
        .NUM_CH(NUM_CH), .STEP_W(STEP_W), .SAMP_W(SAMP_W),
        .SETTLE_CYC(4), .TIMEOUT_CYC(TMO)
    ) dut (
        .free_run_clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_steps(cfg_steps), .cfg_samples(cfg_samples), .cfg_dir(cfg_dir),
        .cmp_data(cmp_data), .ps_en(ps_en), .ps_incdec(ps_incdec), .ps_done(ps_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_step(res_step),
        .res_count(res_count), .busy(busy), .done(done), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    // comparator stimulus: constant or toggling every cycle
    bit       tog = 1'b0;
    bit [1:0] cmp_val = 2'b00;
    initial begin
        bit ph;
        ph = 1'b0;
        forever begin
            @(posedge clk); #1;
            ph = ~ph;
            cmp_data = tog ? {ph, ph} : cmp_val;
        end
    end

    // MMCM model: ps_done done_dly cycles after ps_en
    bit auto_done = 1'b1;
    int done_dly  = 5;
    initial forever begin
        @(negedge clk);
        if (ps_en && auto_done) begin
            repeat (done_dly) @(posedge clk);
            #1 ps_done = 1'b1;
            @(posedge clk);
            #1 ps_done = 1'b0;
        end
    end

    int n_psen = 0, n_inc0 = 0, n_inc1 = 0, n_done = 0, n_dbusy = 0, n_beats = 0;
    logic [STEP_W-1:0]    bstep [256];
    logic [NUM_CH*CW-1:0] bcnt  [256];
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (ps_en) begin
                n_psen++;
                if (ps_incdec) n_inc1++; else n_inc0++;
            end
            if (done) begin
                n_done++;
                if (busy) n_dbusy++;
            end
            if (res_valid && res_ready) begin
                if (n_beats < 256) begin
                    bstep[n_beats] = res_step;
                    bcnt[n_beats]  = res_count;
                end
                n_beats++;
            end
        end
    end

    task automatic start_pulse();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk(nm, int'(busy), 0);
        @(negedge clk);
    endtask

    task automatic wait_psen(input string nm);
        int k;
        k = 0;
        @(negedge clk);
        while (!ps_en && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk(nm, int'(ps_en), 1);
    endtask

    typedef struct {
        int       steps;
        int       samples;
        bit       tg;
        bit [1:0] val;
        bit       dir;
        int       e0;
        int       e1;
    } vec_t;

    vec_t tbl [6];
    int   b_psen, b_inc0, b_inc1, b_done, b_dbusy, b_beats;

    task automatic snap();
        b_psen = n_psen; b_inc0 = n_inc0; b_inc1 = n_inc1;
        b_done = n_done; b_dbusy = n_dbusy; b_beats = n_beats;
    endtask

    initial begin
        tbl[0] = '{3, 4, 1'b0, 2'b01, 1'b1,  4,  0};
        tbl[1] = '{1, 0, 1'b0, 2'b11, 1'b0, 16, 16};
        tbl[2] = '{1, 0, 1'b1, 2'b00, 1'b0,  8,  8};
        tbl[3] = '{2, 4, 1'b1, 2'b00, 1'b0,  2,  2};
        tbl[4] = '{2, 5, 1'b0, 2'b10, 1'b1,  0,  5};
        tbl[5] = '{1, 1, 1'b0, 2'b01, 1'b0,  1,  0};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", int'({ps_en, ps_incdec, res_valid, busy, done, err_timeout}), 0);
        chk("reset_data", int'(res_step) + int'(res_count), 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("post_reset_busy", int'(busy), 0);

        // table of full sweeps; cfg is scrambled after start to show it is latched
        for (int v = 0; v < 6; v++) begin
            snap();
            tog = tbl[v].tg; cmp_val = tbl[v].val;
            cfg_steps = STEP_W'(tbl[v].steps);
            cfg_samples = SAMP_W'(tbl[v].samples);
            cfg_dir = tbl[v].dir;
            repeat (2) @(posedge clk);
            start_pulse();
            cfg_steps = 10'd9; cfg_samples = 4'd7; cfg_dir = ~tbl[v].dir;
            wait_idle($sformatf("v%0d_end", v));
            chk($sformatf("v%0d_beats", v), n_beats - b_beats, tbl[v].steps);
            for (int j = 0; j < tbl[v].steps; j++) begin
                chk($sformatf("v%0d_b%0d_step", v, j), int'(bstep[b_beats + j]), j);
                chk($sformatf("v%0d_b%0d_cnt", v, j), int'(bcnt[b_beats + j]),
                    tbl[v].e1 * 32 + tbl[v].e0);
            end
            chk($sformatf("v%0d_psen", v), n_psen - b_psen, (1 + RET) * (tbl[v].steps - 1));
            chk($sformatf("v%0d_fwd_dir", v),
                tbl[v].dir ? n_inc1 - b_inc1 : n_inc0 - b_inc0, tbl[v].steps - 1);
            chk($sformatf("v%0d_ret_dir", v),
                tbl[v].dir ? n_inc0 - b_inc0 : n_inc1 - b_inc1, RET * (tbl[v].steps - 1));
            chk($sformatf("v%0d_done", v), n_done - b_done, 1);
            chk($sformatf("v%0d_done_busy", v), n_dbusy - b_dbusy, 0);
        end
        tog = 1'b0;

        // busy rises the cycle after start
        cfg_steps = 10'd1; cfg_samples = 4'd2; cmp_val = 2'b00;
        @(posedge clk); #1 start = 1'b1;
        @(negedge clk); chk("busy_lat0", int'(busy), 0);
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk); chk("busy_lat1", int'(busy), 1);
        wait_idle("lat_end");

        // start ignored for zero steps, and abort wins over start in IDLE
        snap();
        cfg_steps = 10'd0;
        start_pulse();
        @(negedge clk); chk("zero_steps_busy", int'(busy), 0);
        cfg_steps = 10'd2;
        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        @(negedge clk); chk("start_abort_busy", int'(busy), 0);

        // back-pressure in EMIT
        snap();
        res_ready = 1'b0; cfg_steps = 10'd2; cfg_samples = 4'd4; cmp_val = 2'b10;
        repeat (2) @(posedge clk);
        start_pulse();
        begin
            int k;
            int bad;
            logic [STEP_W-1:0]    s0;
            logic [NUM_CH*CW-1:0] c0;
            k = 0;
            @(negedge clk);
            while (!res_valid && k < 100) begin @(negedge clk); k++; end
            chk("stall_valid", int'(res_valid), 1);
            s0 = res_step; c0 = res_count;
            bad = 0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1 start = (i == 5);
                @(negedge clk);
                if (!res_valid || res_step != s0 || res_count != c0) bad++;
            end
            start = 1'b0;
            chk("stall_stable", bad, 0);
            chk("stall_step", int'(s0), 0);
            chk("stall_count", int'(c0), 4 * 32);
            chk("stall_no_psen", n_psen - b_psen, 0);
        end
        @(posedge clk); #1 res_ready = 1'b1;
        wait_idle("stall_end");
        chk("stall_beats", n_beats - b_beats, 2);
        chk("stall_psen", n_psen - b_psen, 1 + RET);
        chk("stall_done", n_done - b_done, 1);

        // ps_done never arrives
        snap();
        auto_done = 1'b0; cfg_steps = 10'd2; cfg_samples = 4'd2;
        start_pulse();
        wait_psen("tmo_psen");
        begin
            int bad;
            bad = 0;
            for (int k = 1; k <= TMO; k++) begin
                @(negedge clk);
                if (k < TMO && (err_timeout || !busy)) bad++;
            end
            chk("tmo_early", bad, 0);
            chk("tmo_err", int'(err_timeout), 1);
            chk("tmo_busy", int'(busy), 0);
        end
        @(negedge clk);
        chk("tmo_no_done", n_done - b_done, 0);
        auto_done = 1'b1; cfg_steps = 10'd1; cfg_samples = 4'd1;
        @(posedge clk); #1 start = 1'b1;
        @(negedge clk); chk("tmo_sticky", int'(err_timeout), 1);
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk); chk("tmo_cleared", int'(err_timeout), 0);
        wait_idle("tmo_restart_end");

        // abort in SAMPLE
        snap();
        cfg_steps = 10'd2; cfg_samples = 4'd8;
        start_pulse();
        @(posedge clk); #1 abort = 1'b1;
        @(negedge clk); chk("abs_busy_before", int'(busy), 1);
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abs_busy", int'(busy), 0);
        chk("abs_valid", int'(res_valid), 0);
        repeat (3) @(negedge clk);
        chk("abs_no_done", n_done - b_done, 0);
        chk("abs_no_beat", n_beats - b_beats, 0);

        // abort in WAIT_DONE holds until ps_done
        snap();
        done_dly = 10; cfg_steps = 10'd2; cfg_samples = 4'd2;
        start_pulse();
        wait_psen("abw_psen");
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk); chk("abw_busy_hold", int'(busy), 1);
        @(negedge clk); chk("abw_busy_drop", int'(busy), 0);
        @(negedge clk);
        chk("abw_no_done", n_done - b_done, 0);
        chk("abw_beats", n_beats - b_beats, 1);
        done_dly = 5;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
